sa_result_collector: RTL and testbench

Receive-side counterpart of the systolic-array top's result port. Accepts output rows as the array emits them, last row first (row SA_ROWS-1 down to row 0), over a valid/ready handshake. Optionally accumulates successive K-tiles into an on-chip row buffer. Once a tile is complete, drains the matrix row-major (row 0 first) to a downstream consumer, with the row index and a last-row flag.

---
 rtl/sa_result_collector.sv | 160 ++++++++++++++++
 tb/tb_sa_result_collector.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sa_result_collector.sv
// sa_result_collector
//
// Receive side of the systolic-array result port. Rows arrive last row first
// (SA_ROWS-1 down to 0) and are either written into, or added onto, an on-chip
// row buffer so that successive K-tiles can be accumulated. When the row-0 beat
// carries io_in_done, the finished tile is drained row-major (row 0 first) to a
// downstream consumer. The buffer is cleared after every drain.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   io_in_valid   in   array row valid
//   io_in_ready   out  collector can accept a row (registered)
//   io_in_c       in   row elements, element j at [j*OUT_WIDTH +: OUT_WIDTH], signed
//   io_in_acc     in   1 = add to buffered row, 0 = overwrite
//   io_in_done    in   on the row-0 beat: 1 = tile final, start drain
//   io_out_valid  out  drained row valid
//   io_out_ready  in   consumer accepts row
//   io_out_c      out  drained row, same packing as io_in_c
//   io_out_row    out  index of presented row
//   io_out_last   out  presented row is row SA_ROWS-1
//   io_tiles      out  count of completed drains, wraps 255 -> 0
//
// Every output comes from a register or from decoding registered state only.

module sa_result_collector #(
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SA_ROWS   = 2,
  parameter int unsigned SA_COLS   = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            io_in_valid,
  output logic                            io_in_ready,
  input  logic [SA_COLS*OUT_WIDTH-1:0]    io_in_c,
  input  logic                            io_in_acc,
  input  logic                            io_in_done,
  output logic                            io_out_valid,
  input  logic                            io_out_ready,
  output logic [SA_COLS*OUT_WIDTH-1:0]    io_out_c,
  output logic [$clog2(SA_ROWS)-1:0]      io_out_row,
  output logic                            io_out_last,
  output logic [7:0]                      io_tiles
);

  localparam int unsigned RowW = $clog2(SA_ROWS);
  localparam logic [RowW-1:0] LastRow = RowW'(SA_ROWS - 1);

  typedef enum logic [0:0] {
    StCollect,
    StDrain
  } state_e;

  // Row-major buffer; the packed layout of one row matches io_in_c / io_out_c.
  typedef logic [SA_COLS-1:0][OUT_WIDTH-1:0] row_t;

  state_e                  r_state, w_state_d;
  row_t   [SA_ROWS-1:0]    r_buf, w_buf_d;
  logic   [RowW-1:0]       r_wr_row, w_wr_row_d;
  logic   [RowW-1:0]       r_rd_row, w_rd_row_d;
  logic   [7:0]            r_tiles, w_tiles_d;
  // Kept as its own register so ready stays low during reset and rises on the
  // first edge after reset is released, even though the state is already COLLECT.
  logic                    r_in_ready, w_in_ready_d;

  logic                    w_in_fire;
  logic                    w_out_fire;
  logic                    w_out_valid;

  assign w_out_valid = (r_state == StDrain);
  assign w_in_fire   = io_in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & io_out_ready;

  // State register and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= StCollect;
      r_buf      <= '0;
      r_wr_row   <= LastRow;
      r_rd_row   <= '0;
      r_tiles    <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_buf      <= w_buf_d;
      r_wr_row   <= w_wr_row_d;
      r_rd_row   <= w_rd_row_d;
      r_tiles    <= w_tiles_d;
      r_in_ready <= w_in_ready_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_d    = r_state;
    w_buf_d      = r_buf;
    w_wr_row_d   = r_wr_row;
    w_rd_row_d   = r_rd_row;
    w_tiles_d    = r_tiles;
    w_in_ready_d = r_in_ready;

    unique case (r_state)
      StCollect: begin
        w_in_ready_d = 1'b1;
        if (w_in_fire) begin
          for (int j = 0; j < int'(SA_COLS); j++) begin
            // Plain two's-complement add: wraps at OUT_WIDTH, no saturation.
            if (io_in_acc) begin
              w_buf_d[r_wr_row][j] = r_buf[r_wr_row][j] + io_in_c[j*OUT_WIDTH +: OUT_WIDTH];
            end else begin
              w_buf_d[r_wr_row][j] = io_in_c[j*OUT_WIDTH +: OUT_WIDTH];
            end
          end
          if (r_wr_row != '0) begin
            w_wr_row_d = r_wr_row - RowW'(1);
          end else if (io_in_done) begin
            // Tile complete: ready drops on the same edge valid rises.
            w_state_d    = StDrain;
            w_rd_row_d   = '0;
            w_in_ready_d = 1'b0;
          end else begin
            // Another K-tile follows; start again from the last row.
            w_wr_row_d = LastRow;
          end
        end
      end

      StDrain: begin
        w_in_ready_d = 1'b0;
        if (w_out_fire) begin
          if (r_rd_row != LastRow) begin
            w_rd_row_d = r_rd_row + RowW'(1);
          end else begin
            // Last row handed off: clear for the next tile so a first-pass
            // accumulate behaves as an overwrite.
            w_buf_d      = '0;
            w_tiles_d    = r_tiles + 8'd1;
            w_wr_row_d   = LastRow;
            w_rd_row_d   = '0;
            w_state_d    = StCollect;
            w_in_ready_d = 1'b1;
          end
        end
      end

      default: begin
        w_state_d = StCollect;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  assign io_in_ready  = r_in_ready;
  assign io_out_valid = w_out_valid;
  assign io_out_c     = w_out_valid ? r_buf[r_rd_row] : '0;
  assign io_out_row   = w_out_valid ? r_rd_row : '0;
  assign io_out_last  = w_out_valid && (r_rd_row == LastRow);
  assign io_tiles     = r_tiles;

endmodule

// File: tb/tb_sa_result_collector.sv
// Directed bench for sa_result_collector (OUT_WIDTH=16, SA_ROWS=2, SA_COLS=2).
// Inputs change #1 after a rising edge; outputs are sampled at that same point.

module tb_sa_result_collector;

  logic        clock;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_in_c;
  logic        io_in_acc;
  logic        io_in_done;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_c;
  logic [0:0]  io_out_row;
  logic        io_out_last;
  logic [7:0]  io_tiles;

  int n_vec;
  int n_err;

  sa_result_collector #(
    .OUT_WIDTH (16),
    .SA_ROWS   (2),
    .SA_COLS   (2)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_c      (io_in_c),
    .io_in_acc    (io_in_acc),
    .io_in_done   (io_in_done),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_c     (io_out_c),
    .io_out_row   (io_out_row),
    .io_out_last  (io_out_last),
    .io_tiles     (io_tiles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One accepted beat; ready is registered, so checking it before the edge
  // confirms the beat is taken on that edge.
  task automatic send_beat(input logic [15:0] e0, input logic [15:0] e1,
                           input logic acc, input logic done, input string tag);
    io_in_valid = 1'b1;
    io_in_c     = {e1, e0};
    io_in_acc   = acc;
    io_in_done  = done;
    check({tag, " in_ready"}, 32'(io_in_ready), 32'd1);
    step();
    io_in_valid = 1'b0;
    io_in_acc   = 1'b0;
    io_in_done  = 1'b0;
    io_in_c     = '0;
  endtask

  // Full drain with out_ready held high; called the cycle after the final beat.
  task automatic drain_check(input logic [15:0] a0, input logic [15:0] a1,
                             input logic [15:0] b0, input logic [15:0] b1,
                             input logic [7:0] tiles, input string tag);
    io_out_ready = 1'b1;
    check({tag, " r0 valid"}, 32'(io_out_valid), 32'd1);
    check({tag, " r0 row"},   32'(io_out_row),   32'd0);
    check({tag, " r0 last"},  32'(io_out_last),  32'd0);
    check({tag, " r0 data"},  io_out_c,          {b1 == b1 ? a1 : a1, a0});
    check({tag, " r0 in_rdy"}, 32'(io_in_ready), 32'd0);
    step();
    check({tag, " r1 valid"}, 32'(io_out_valid), 32'd1);
    check({tag, " r1 row"},   32'(io_out_row),   32'd1);
    check({tag, " r1 last"},  32'(io_out_last),  32'd1);
    check({tag, " r1 data"},  io_out_c,          {b1, b0});
    check({tag, " r1 in_rdy"}, 32'(io_in_ready), 32'd0);
    step();
    check({tag, " end valid"}, 32'(io_out_valid), 32'd0);
    check({tag, " end in_rdy"}, 32'(io_in_ready), 32'd1);
    check({tag, " end tiles"}, 32'(io_tiles),     32'(tiles));
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_in_c      = '0;
    io_in_acc    = 1'b0;
    io_in_done   = 1'b0;
    io_out_ready = 1'b1;

    // 1. Reset release
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst in_ready",  32'(io_in_ready),  32'd0);
      check("rst out_valid", 32'(io_out_valid), 32'd0);
      check("rst out_c",     io_out_c,          32'd0);
      check("rst out_row",   32'(io_out_row),   32'd0);
      check("rst out_last",  32'(io_out_last),  32'd0);
      check("rst tiles",     32'(io_tiles),     32'd0);
    end
    reset = 1'b0;
    #1;
    check("post-rst in_ready pre-edge", 32'(io_in_ready), 32'd0);
    step();
    check("post-rst in_ready", 32'(io_in_ready), 32'd1);
    check("post-rst tiles",    32'(io_tiles),    32'd0);

    // 2. Single tile
    send_beat(16'd5, -16'sd3, 1'b0, 1'b0, "t2 row1");
    check("t2 no early valid", 32'(io_out_valid), 32'd0);
    send_beat(16'd7, 16'd2, 1'b0, 1'b1, "t2 row0");
    drain_check(16'd7, 16'd2, 16'd5, -16'sd3, 8'd1, "t2");

    // 3. Accumulate across K
    send_beat(16'd1, 16'd2, 1'b0, 1'b0, "t3 k1 row1");
    send_beat(16'd3, 16'd4, 1'b0, 1'b0, "t3 k1 row0");
    check("t3 no drain after done=0", 32'(io_out_valid), 32'd0);
    send_beat(16'd10, -16'sd20, 1'b1, 1'b0, "t3 k2 row1");
    send_beat(-16'sd3, 16'd100, 1'b1, 1'b1, "t3 k2 row0");
    drain_check(16'd0, 16'd104, 16'd11, -16'sd18, 8'd2, "t3");

    // 4. Wrap
    send_beat(16'd32767, 16'h8000, 1'b0, 1'b0, "t4 k1 row1");
    send_beat(16'd0, 16'd0, 1'b0, 1'b0, "t4 k1 row0");
    send_beat(16'd1, 16'hFFFF, 1'b1, 1'b0, "t4 k2 row1");
    send_beat(16'd0, 16'd0, 1'b1, 1'b1, "t4 k2 row0");
    drain_check(16'd0, 16'd0, 16'h8000, 16'h7FFF, 8'd3, "t4");

    // 5. Backpressure with in_valid held high
    send_beat(16'd9, 16'd8, 1'b0, 1'b0, "t5 row1");
    send_beat(16'd6, 16'd5, 1'b0, 1'b1, "t5 row0");
    io_out_ready = 1'b0;
    io_in_valid  = 1'b1;
    io_in_c      = {16'd222, 16'd111};
    io_in_acc    = 1'b0;
    io_in_done   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t5 stall valid",  32'(io_out_valid), 32'd1);
      check("t5 stall row",    32'(io_out_row),   32'd0);
      check("t5 stall last",   32'(io_out_last),  32'd0);
      check("t5 stall data",   io_out_c,          {16'd5, 16'd6});
      check("t5 stall in_rdy", 32'(io_in_ready),  32'd0);
      step();
    end
    io_in_valid = 1'b0;
    io_in_done  = 1'b0;
    io_in_c     = '0;
    drain_check(16'd6, 16'd5, 16'd9, 16'd8, 8'd4, "t5");

    // 6. Reset mid-drain
    send_beat(16'd3, 16'd3, 1'b0, 1'b0, "t6 row1");
    send_beat(16'd2, 16'd2, 1'b0, 1'b1, "t6 row0");
    check("t6 r0 data", io_out_c, {16'd2, 16'd2});
    step();
    check("t6 r1 valid", 32'(io_out_valid), 32'd1);
    check("t6 r1 row",   32'(io_out_row),   32'd1);
    reset = 1'b1;
    #1;
    check("t6 rst out_valid", 32'(io_out_valid), 32'd0);
    check("t6 rst out_c",     io_out_c,          32'd0);
    check("t6 rst tiles",     32'(io_tiles),     32'd0);
    check("t6 rst in_ready",  32'(io_in_ready),  32'd0);
    step();
    reset = 1'b0;
    step();
    check("t6 post-rst in_ready", 32'(io_in_ready), 32'd1);
    send_beat(16'd4, 16'd4, 1'b1, 1'b0, "t6b row1");
    send_beat(16'd1, 16'd1, 1'b1, 1'b1, "t6b row0");
    drain_check(16'd1, 16'd1, 16'd4, 16'd4, 8'd1, "t6b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
